// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and the future transmitter.
//   OVERSAMPLE - oversample ticks per bit period
//   MID_SAMPLE - ticks from the start edge to the start-bit midpoint
//   DATA_BITS  - data bits per frame
//   uart_state_t - receiver/transmitter FSM state encoding
//   even_parity_err() - 1 when data plus received parity bit has odd weight
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 8;
    localparam int unsigned DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_t;

    function automatic logic even_parity_err(input logic [DATA_BITS-1:0] data,
                                             input logic                 par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator.
//   Counts 0..DIV-1 and pulses tick for one clock while the count is DIV-1.
//   restart forces the count back to 0 so the next tick lands DIV clocks later.
// Ports:
//   clk     - system clock, rising edge
//   rst_n   - asynchronous active-low reset
//   restart - synchronous counter restart
//   tick    - one-clock pulse every DIV clocks
module uart_baud_tick #(
    parameter int unsigned DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled asynchronous receiver for 8-bit frames
//   (start, 8 data LSB-first, optional even parity, 1 stop).
// Build option:
//   UART_RX_PARITY_EN - adds the parity bit to the frame and the PARITY_ERR port.
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   UART_RX    - serial line, idle high, asynchronous to clk
//   RX_DATA    - last received byte, updated at the stop-bit sample
//   RX_STATUS  - high from confirmed start midpoint until the frame completes;
//                its falling edge marks RX_DATA valid
//   FRAME_ERR  - stop bit of the last frame sampled low
//   PARITY_ERR - parity mismatch on the last frame (parity build only)
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115_200,
    parameter int unsigned DIV      = CLK_FREQ / (BAUD * 16)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       UART_RX,
    output logic [7:0] RX_DATA,
    output logic       RX_STATUS,
    output logic       FRAME_ERR
`ifdef UART_RX_PARITY_EN
    ,
    output logic       PARITY_ERR
`endif
);

    localparam logic [3:0] OS_LAST  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_LAST = 4'(MID_SAMPLE - 1);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Input conditioning: 2-FF synchronizer plus edge register.
    // These reset low so that a line already low at reset release is not
    // mistaken for a start edge; the line must be seen high first.
    // ------------------------------------------------------------------
    logic sync1;
    logic sync2;
    logic line_q;
    logic line;
    logic fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            line_q <= 1'b0;
        end else begin
            sync1  <= UART_RX;
            sync2  <= sync1;
            line_q <= sync2;
        end
    end

    assign line = sync2;
    assign fall = line_q & ~sync2;

    // ------------------------------------------------------------------
    // Oversample tick, re-phased to the detected start edge
    // ------------------------------------------------------------------
    uart_state_t state;
    logic        restart;
    logic        tick;

    assign restart = (state == IDLE) && fall;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(restart),
        .tick   (tick)
    );

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    logic [3:0] os_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       done;
`ifdef UART_RX_PARITY_EN
    logic       par_bit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            done       <= 1'b0;
            RX_DATA    <= '0;
            RX_STATUS  <= 1'b0;
            FRAME_ERR  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            PARITY_ERR <= 1'b0;
`endif
        end else begin
            // RX_STATUS drops one clock after RX_DATA is loaded so that the
            // falling edge always sees the new byte.
            done <= 1'b0;
            if (done) begin
                RX_STATUS <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (fall) begin
                        state   <= START;
                        os_cnt  <= '0;
                        bit_cnt <= '0;
                    end
                end

                START: begin
                    if (tick) begin
                        if (os_cnt == MID_LAST) begin
                            os_cnt <= '0;
                            if (!line) begin
                                RX_STATUS <= 1'b1;
                                state     <= DATA;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (os_cnt == OS_LAST) begin
                            os_cnt  <= '0;
                            shreg   <= {line, shreg[7:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (os_cnt == OS_LAST) begin
                            os_cnt  <= '0;
                            par_bit <= line;
                            state   <= STOP;
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end
`endif

                STOP: begin
                    if (tick) begin
                        if (os_cnt == OS_LAST) begin
                            os_cnt     <= '0;
                            RX_DATA    <= shreg;
                            FRAME_ERR  <= ~line;
`ifdef UART_RX_PARITY_EN
                            PARITY_ERR <= even_parity_err(shreg, par_bit);
`endif
                            done       <= 1'b1;
                            state      <= line ? IDLE : BREAK;
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end

                BREAK: begin
                    // A low stop bit may be a line break; only a high line
                    // re-arms start detection.
                    if (line) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 115_200;
    localparam int DIV      = CLK_FREQ / (BAUD * 16);
    localparam int BIT_CLKS = DIV * 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       UART_RX = 1'b1;
    logic [7:0] RX_DATA;
    logic       RX_STATUS;
    logic       FRAME_ERR;
`ifdef UART_RX_PARITY_EN
    logic       PARITY_ERR;
`endif

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .UART_RX   (UART_RX),
        .RX_DATA   (RX_DATA),
        .RX_STATUS (RX_STATUS),
        .FRAME_ERR (FRAME_ERR)
`ifdef UART_RX_PARITY_EN
        ,
        .PARITY_ERR(PARITY_ERR)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference-side bookkeeping
    int         exp_rises = 0;
    logic [7:0] last_byte = 8'h00;

    // Observed frames: captured at each RX_STATUS falling edge
    int         rise_cnt = 0;
    logic       st_prev  = 1'b0;
    logic [7:0] q_data[$];
    logic       q_ferr[$];
    logic       q_perr[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            st_prev = 1'b0;
        end else begin
            if (!st_prev && RX_STATUS) rise_cnt++;
            if (st_prev && !RX_STATUS) begin
                q_data.push_back(RX_DATA);
                q_ferr.push_back(FRAME_ERR);
`ifdef UART_RX_PARITY_EN
                q_perr.push_back(PARITY_ERR);
`else
                q_perr.push_back(1'b0);
`endif
            end
            st_prev = RX_STATUS;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: the serial picture of a frame and its expected flags
    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    function automatic logic exp_perr(input logic [7:0] d, input logic p);
`ifdef UART_RX_PARITY_EN
        return (^d) ^ p;
`else
        return 1'b0 & p & (^d);
`endif
    endfunction

    task automatic hold(input logic v, input int n);
        UART_RX = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
        bits = {stop_b, par_b, d, 1'b0};
`else
        bits = {par_b, stop_b, d, 1'b0};
`endif
        for (int i = 0; i < FRAME_BITS; i++) hold(bits[i], BIT_CLKS);
    endtask

    task automatic clear_q();
        q_data.delete();
        q_ferr.delete();
        q_perr.delete();
    endtask

    task automatic wait_frames(input int n, input string name);
        int k = 0;
        while (q_data.size() < n && k < 3 * BIT_CLKS) begin
            @(posedge clk);
            k++;
        end
        #1;
        total++;
        if (q_data.size() != n) begin
            bad++;
            $display("FAIL %s_frame_count: got %0d want %0d", name, q_data.size(), n);
        end
    endtask

    // Compare the first n captured frames against expected tables
    task automatic check_frames(input string name, input int n,
                                input logic [7:0] ed[], input logic ef[], input logic ep[]);
        for (int i = 0; i < n; i++) begin
            if (i < q_data.size()) begin
                total++;
                if (q_data[i] !== ed[i]) begin
                    bad++;
                    $display("FAIL %s_data[%0d]: got %02h want %02h", name, i, q_data[i], ed[i]);
                end
                total++;
                if (q_ferr[i] !== ef[i]) begin
                    bad++;
                    $display("FAIL %s_ferr[%0d]: got %b want %b", name, i, q_ferr[i], ef[i]);
                end
`ifdef UART_RX_PARITY_EN
                total++;
                if (q_perr[i] !== ep[i]) begin
                    bad++;
                    $display("FAIL %s_perr[%0d]: got %b want %b", name, i, q_perr[i], ep[i]);
                end
`endif
            end
        end
        if (ep.size() != n) $display("note: %s parity table size %0d", name, ep.size());
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        UART_RX = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (RX_DATA !== 8'h00) begin bad++; $display("FAIL reset_data: got %02h want 00", RX_DATA); end
        total++;
        if (RX_STATUS !== 1'b0) begin bad++; $display("FAIL reset_status: got %b want 0", RX_STATUS); end
        total++;
        if (FRAME_ERR !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", FRAME_ERR); end
`ifdef UART_RX_PARITY_EN
        total++;
        if (PARITY_ERR !== 1'b0) begin bad++; $display("FAIL reset_perr: got %b want 0", PARITY_ERR); end
`endif
        rst_n = 1'b1;
        hold(1'b1, 2 * BIT_CLKS);
    endtask

    // 0x55, with the start-to-RX_STATUS latency measured from the line edge
    task automatic test_basic_frame();
        logic [7:0] d   = 8'h55;
        int         lat = -1;
        clear_q();
        UART_RX = 1'b0;
        for (int c = 1; c <= BIT_CLKS; c++) begin
            @(posedge clk);
            #1;
            if (RX_STATUS && lat < 0) lat = c;
        end
        for (int i = 0; i < 8; i++) hold(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
        hold(even_par(d), BIT_CLKS);
`endif
        hold(1'b1, BIT_CLKS);
        exp_rises++;
        wait_frames(1, "basic");
        // 3 clocks of input latency plus 8*DIV to the start midpoint
        total++;
        if (lat < 8 * DIV + 2 || lat > 8 * DIV + 4) begin
            bad++;
            $display("FAIL basic_latency: got %0d want %0d..%0d", lat, 8 * DIV + 2, 8 * DIV + 4);
        end
        check_frames("basic", 1, '{d}, '{1'b0}, '{1'b0});
        last_byte = d;
        total++;
        if (RX_STATUS !== 1'b0) begin bad++; $display("FAIL basic_status_low: got %b want 0", RX_STATUS); end
    endtask

    task automatic test_glitch();
        clear_q();
        hold(1'b0, 5 * DIV);
        hold(1'b1, 2 * BIT_CLKS);
        total++;
        if (rise_cnt !== exp_rises) begin bad++; $display("FAIL glitch_rises: got %0d want %0d", rise_cnt, exp_rises); end
        total++;
        if (q_data.size() != 0) begin bad++; $display("FAIL glitch_frames: got %0d want 0", q_data.size()); end
        total++;
        if (RX_DATA !== last_byte) begin bad++; $display("FAIL glitch_data: got %02h want %02h", RX_DATA, last_byte); end
    endtask

    task automatic test_break();
        clear_q();
        send_frame(8'hA3, 1'b0, even_par(8'hA3));
        hold(1'b0, 2 * BIT_CLKS);
        total++;
        if (RX_STATUS !== 1'b0) begin bad++; $display("FAIL break_status: got %b want 0", RX_STATUS); end
        hold(1'b1, BIT_CLKS);
        send_frame(8'h3C, 1'b1, even_par(8'h3C));
        hold(1'b1, 4);
        exp_rises += 2;
        wait_frames(2, "break");
        check_frames("break", 2, '{8'hA3, 8'h3C}, '{1'b1, 1'b0}, '{1'b0, 1'b0});
        total++;
        if (FRAME_ERR !== 1'b0) begin bad++; $display("FAIL break_ferr_final: got %b want 0", FRAME_ERR); end
        last_byte = 8'h3C;
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[3] = '{8'h00, 8'hFF, 8'h80};
        clear_q();
        for (int i = 0; i < 3; i++) send_frame(b[i], 1'b1, even_par(b[i]));
        hold(1'b1, 4);
        exp_rises += 3;
        wait_frames(3, "b2b");
        check_frames("b2b", 3, '{8'h00, 8'hFF, 8'h80}, '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0});
        total++;
        if (rise_cnt !== exp_rises) begin bad++; $display("FAIL b2b_rises: got %0d want %0d", rise_cnt, exp_rises); end
        last_byte = 8'h80;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d = 8'h5A;
        clear_q();
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) hold(d[i], BIT_CLKS);
        hold(d[4], BIT_CLKS / 2);
        exp_rises++;
        rst_n = 1'b0;
        UART_RX = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (RX_DATA !== 8'h00) begin bad++; $display("FAIL midrst_data: got %02h want 00", RX_DATA); end
        total++;
        if (RX_STATUS !== 1'b0) begin bad++; $display("FAIL midrst_status: got %b want 0", RX_STATUS); end
        rst_n = 1'b1;
        hold(1'b1, 2 * BIT_CLKS);
        total++;
        if (q_data.size() != 0) begin bad++; $display("FAIL midrst_frames: got %0d want 0", q_data.size()); end
        total++;
        if (RX_DATA !== 8'h00) begin bad++; $display("FAIL midrst_data_after: got %02h want 00", RX_DATA); end
        total++;
        if (FRAME_ERR !== 1'b0) begin bad++; $display("FAIL midrst_ferr: got %b want 0", FRAME_ERR); end
        send_frame(8'h12, 1'b1, even_par(8'h12));
        hold(1'b1, 4);
        exp_rises++;
        wait_frames(1, "midrst");
        check_frames("midrst", 1, '{8'h12}, '{1'b0}, '{1'b0});
        last_byte = 8'h12;
    endtask

    task automatic test_random();
        logic [7:0] ed[3];
        logic       ef[3];
        logic       ep[3];
        clear_q();
        for (int i = 0; i < 3; i++) begin
            logic [7:0] d = 8'($urandom);
            logic       p = 1'($urandom);
            send_frame(d, 1'b1, p);
            ed[i] = d;
            ef[i] = 1'b0;
            ep[i] = exp_perr(d, p);
            hold(1'b1, $urandom_range(0, 60));
        end
        hold(1'b1, 4);
        exp_rises += 3;
        wait_frames(3, "rand");
        check_frames("rand", 3, ed, ef, ep);
        total++;
        if (rise_cnt !== exp_rises) begin bad++; $display("FAIL rand_rises: got %0d want %0d", rise_cnt, exp_rises); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_q();
        send_frame(8'h81, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 1'b1);
        hold(1'b1, 4);
        exp_rises += 2;
        wait_frames(2, "parity");
        check_frames("parity", 2, '{8'h81, 8'h81}, '{1'b0, 1'b0}, '{1'b0, 1'b1});
        total++;
        if (PARITY_ERR !== 1'b1) begin bad++; $display("FAIL parity_flag_hold: got %b want 1", PARITY_ERR); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_glitch();
        test_break();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
